// File: rtl/regf_wb_arbiter.sv
// regf_wb_arbiter: shares the register file's single write port between NREQ writeback
// sources. One request per cycle is granted by round-robin and registered onto the
// register file write port, so a write reaches the port one cycle after its accept.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   hold       stall; no grant is issued while high
//   req_valid  per-source write request valid              [NREQ]
//   req_addr   flattened destination addresses, src i at [i*AW +: AW]
//   req_data   flattened write data, src i at [i*DW +: DW]
//   req_ready  per-source grant (combinational)             [NREQ]
//   w_enable   register file write enable (registered)
//   w_addr     register file write address (registered)
//   w_data     register file write data (registered)
//   busy       some request is valid but none is granted this cycle
//
// Optional feature macro: REGF_WB_X0_DROP_EN. When defined, requests to address 0 are
// readied immediately alongside the normal winner, never write and never move the
// round-robin pointer; the normal winner is picked among non-zero addresses only.

`timescale 1ns/1ps

module regf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               w_enable,
    output logic [AW-1:0]      w_addr,
    output logic [DW-1:0]      w_data,
    output logic               busy
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [RW-1:0]   rr_q;
    logic [RW-1:0]   rr_d;
    logic [NREQ-1:0] cand;        // requests competing for the write slot
    logic [NREQ-1:0] side_ready;  // requests readied outside the round-robin search
    logic            win_found;
    logic [RW-1:0]   win_idx;
    logic [NREQ-1:0] win_onehot;
    logic            grant_en;
    logic            accept;

`ifdef REGF_WB_X0_DROP_EN
    logic [NREQ-1:0] x0_req;

    always_comb begin
        x0_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            x0_req[i] = (req_addr[i*AW +: AW] == '0);
        end
    end

    assign cand       = req_valid & ~x0_req;
    assign side_ready = req_valid & x0_req;
`else
    assign cand       = req_valid;
    assign side_ready = '0;
`endif

    // Round-robin search starting at rr_q, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[RW-1:0];
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        if (win_found) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

    // Grants are suppressed during reset so nothing looks accepted while rst is high.
    assign grant_en  = ~hold & ~rst;
    assign req_ready = grant_en ? (win_onehot | side_ready) : '0;
    assign accept    = grant_en & win_found;
    assign busy      = (|req_valid) & ~(|(req_valid & req_ready));

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (win_idx == RW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q     <= '0;
            w_enable <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
        end else begin
            rr_q     <= rr_d;
            w_enable <= accept;
            if (accept) begin
                w_addr <= req_addr[win_idx*AW +: AW];
                w_data <= req_data[win_idx*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Self-checking bench for regf_wb_arbiter (NREQ=3, AW=5, DW=32). A reference model
// tracks the round-robin pointer and write-port contents and is compared against the
// DUT on every falling edge; directed scenarios add hand-computed literal checks.

`timescale 1ns/1ps

module tb_regf_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            w_enable;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    regf_wb_arbiter #(
        .NREQ (N),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .w_enable  (w_enable),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_src(input int s, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[s]          = v;
        req_addr[s*AW +: AW]  = a;
        req_data[s*DW +: DW]  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: state after the most recent rising edge.
    int            m_rr   = 0;
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    function automatic logic is_dropped_x0(input int s);
`ifdef REGF_WB_X0_DROP_EN
        return req_addr[s*AW +: AW] == '0;
`else
        return 1'b0;
`endif
    endfunction

    // Inputs only change just after a rising edge, so the falling edge sees what the
    // next rising edge will act on.
    always @(negedge clk) begin
        int           win;
        int           s;
        logic [N-1:0] er;
        logic         eb;
        if (rst) begin
            m_rr   = 0;
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
            check("model_rst_ready", req_ready, 0);
            check("model_rst_wen", w_enable, 0);
            check("model_rst_waddr", w_addr, 0);
            check("model_rst_wdata", w_data, 0);
        end else begin
            win = -1;
            er  = '0;
            if (!hold) begin
                for (int k = 0; k < N; k++) begin
                    s = (m_rr + k) % N;
                    if (win < 0 && req_valid[s] && !is_dropped_x0(s)) win = s;
                end
                if (win >= 0) er[win] = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && is_dropped_x0(i)) er[i] = 1'b1;
                end
            end
            eb = (req_valid != '0) && ((req_valid & er) == '0);
            check("model_ready", req_ready, er);
            check("model_busy", busy, eb);
            check("model_wen", w_enable, m_we);
            check("model_waddr", w_addr, m_addr);
            check("model_wdata", w_data, m_data);
            if (win >= 0) begin
                m_we   = 1'b1;
                m_addr = req_addr[win*AW +: AW];
                m_data = req_data[win*DW +: DW];
                m_rr   = (win + 1) % N;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    logic [AW-1:0] rr_addr_seq [4];

    initial begin
        rr_addr_seq = '{5'd1, 5'd2, 5'd3, 5'd1};
        hold      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rst       = 1'b0;
        #1 rst = 1'b1;

        // Reset: nothing granted even with every source valid
        set_src(0, 1'b1, 5'd1, 32'hA1);
        set_src(1, 1'b1, 5'd2, 32'hA2);
        set_src(2, 1'b1, 5'd3, 32'hA3);
        #1;
        check("reset_ready", req_ready, 3'b000);
        check("reset_wen", w_enable, 0);
        check("reset_waddr", w_addr, 0);
        check("reset_wdata", w_data, 0);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single source
        set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1 check("single_ready", req_ready, 3'b010);
        tick();
        check("single_wen", w_enable, 1);
        check("single_waddr", w_addr, 5);
        check("single_wdata", w_data, 32'hDEADBEEF);
        set_src(1, 1'b0, 5'd0, 32'h0);
        tick();
        check("single_wen_off", w_enable, 0);

        // Asynchronous reset while a write is on the port
        set_src(1, 1'b1, 5'd9, 32'h1234);
        tick();
        check("midrst_wen_before", w_enable, 1);
        set_src(1, 1'b0, 5'd0, 32'h0);
        set_src(0, 1'b1, 5'd6, 32'h66);
        #2 rst = 1'b1;
        #1;
        check("midrst_wen", w_enable, 0);
        check("midrst_waddr", w_addr, 0);
        check("midrst_wdata", w_data, 0);
        check("midrst_ready", req_ready, 3'b000);
        set_src(0, 1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b0;

        // Round-robin from reset: rr must have returned to 0
        set_src(0, 1'b1, 5'd1, 32'hA1);
        set_src(1, 1'b1, 5'd2, 32'hA2);
        set_src(2, 1'b1, 5'd3, 32'hA3);
        #1 check("rr_first_ready", req_ready, 3'b001);
        for (int j = 0; j < 4; j++) begin
            tick();
            check("rr_wen", w_enable, 1);
            check("rr_waddr", w_addr, rr_addr_seq[j]);
        end

        // Hold for 4 cycles: rr stays at 1
        hold = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("hold_ready", req_ready, 3'b000);
            check("hold_busy", busy, 1);
            tick();
            check("hold_wen", w_enable, 0);
        end
        hold = 1'b0;
        #1 check("hold_resume_ready", req_ready, 3'b010);
        tick();
        check("hold_resume_waddr", w_addr, 2);

        // Steer rr back to 0 via a lone src2 grant
        set_src(0, 1'b0, 5'd0, 32'h0);
        set_src(1, 1'b0, 5'd0, 32'h0);
        tick();
        check("steer_waddr", w_addr, 3);
        set_src(2, 1'b0, 5'd0, 32'h0);

        // Same-address race: grant order src0 then src2
        set_src(0, 1'b1, 5'd7, 32'h11);
        set_src(2, 1'b1, 5'd7, 32'h22);
        tick();
        check("race_waddr0", w_addr, 7);
        check("race_wdata0", w_data, 32'h11);
        set_src(0, 1'b0, 5'd0, 32'h0);
        tick();
        check("race_waddr1", w_addr, 7);
        check("race_wdata1", w_data, 32'h22);
        set_src(2, 1'b0, 5'd0, 32'h0);
        tick();
        check("race_wen_off", w_enable, 0);

        // Request withdrawn before it was ever granted
        hold = 1'b1;
        set_src(1, 1'b1, 5'd12, 32'hCC);
        tick();
        set_src(1, 1'b0, 5'd0, 32'h0);
        hold = 1'b0;
        tick();
        check("withdraw_wen", w_enable, 0);

`ifdef REGF_WB_X0_DROP_EN
        set_src(0, 1'b1, 5'd0, 32'h99);
        set_src(1, 1'b1, 5'd4, 32'h44);
        #1 check("x0_ready", req_ready, 3'b011);
        tick();
        check("x0_wen", w_enable, 1);
        check("x0_waddr", w_addr, 4);
        set_src(0, 1'b1, 5'd6, 32'h66);
        set_src(1, 1'b0, 5'd0, 32'h0);
        set_src(2, 1'b1, 5'd8, 32'h88);
        #1 check("x0_rr_is_2", req_ready, 3'b100);
        tick();
        req_valid = '0;
`else
        set_src(0, 1'b1, 5'd0, 32'h55);
        #1 check("x0_ready", req_ready, 3'b001);
        tick();
        check("x0_wen", w_enable, 1);
        check("x0_waddr", w_addr, 0);
        check("x0_wdata", w_data, 32'h55);
        set_src(0, 1'b0, 5'd0, 32'h0);
`endif
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
